core_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the RISC-V datapath through the FETCH, DECODE, EXECUTE and WRITEBACK stages, one instruction at a time.
- Owns the program counter and gates the fetch read enable and register-file write.
- Supports run/halt/single-step control and traps on unsupported opcodes.
- Sits above the datapath, between the external debug/test controller and the stage modules.

---
 rtl/core_sequencer.sv | 156 +++++++++++++++
 tb/tb_core_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM with run/halt/step and traps
// Optional fetch watchdog enabled by defining SEQ_WATCHDOG_EN.
module core_sequencer #(
    parameter int MEM_SIZE    = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int WDOG_CYCLES = 8,
    localparam int PW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic                 mem_ready,
    input  logic [6:0]           opcode,
    output logic                 rd_en,
    output logic                 ir_load,
    output logic                 reg_write_en,
    output logic [PW-1:0]        pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PAUSE     = 3'd5,
        S_HALT      = 3'd6,
        S_TRAP      = 3'd7
    } state_t;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;

    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

    state_t               state_q, state_d;
    logic [PW-1:0]        pc_q, pc_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic [1:0]           cause_q, cause_d;
    logic                 halt_pending_q, halt_pending_d;

`ifdef SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q, wdog_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            retired_q      <= '0;
            cause_q        <= 2'd0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            retired_q      <= retired_d;
            cause_q        <= cause_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        retired_d      = retired_q;
        cause_d        = cause_q;
        halt_pending_d = halt_pending_q;
        rd_en          = 1'b0;
        ir_load        = 1'b0;
        reg_write_en   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wdog_d         = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (halt_pending_q || halt_req) state_d = S_HALT;
                else if (start)                 state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_en = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
`ifdef SEQ_WATCHDOG_EN
                // mem_ready is checked first so a late response still wins
                else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_DECODE: begin
                if (opcode == OP_R_TYPE || opcode == OP_I_ALU) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXECUTE: state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                reg_write_en = 1'b1;
                pc_d         = (pc_q == PW'(MEM_SIZE - 1)) ? '0 : pc_q + 1'b1;
                retired_d    = (&retired_q) ? retired_q : retired_q + 1'b1;
                if (halt_pending_q) state_d = S_HALT;
                else if (step_mode) state_d = S_PAUSE;
                else                state_d = S_FETCH;
            end
            S_PAUSE: begin
                if (halt_pending_q || halt_req) state_d = S_HALT;
                else if (step || !step_mode)    state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // Entering HALT consumes the request; otherwise halt_req is sticky
        if (state_d == S_HALT && state_q != S_HALT)
            halt_pending_d = 1'b0;
        else if (halt_req && state_q != S_HALT && state_q != S_TRAP)
            halt_pending_d = 1'b1;
    end

    assign pc            = pc_q;
    assign retired_count = retired_q;
    assign trap_cause    = cause_q;
    assign state         = state_q;
    assign busy          = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                           (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
    assign halted        = (state_q == S_HALT);
    assign trap          = (state_q == S_TRAP);

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer
// Covers SEQ_WATCHDOG_EN behaviour when that macro is defined.
module tb_core_sequencer;
    localparam int MEM_SIZE = 16;
    localparam int CNT_W    = 16;
    localparam int WDOG     = 8;
    localparam int PW       = 4;
    localparam int NC       = 240;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic clk = 1'b0;
    logic reset, start, halt_req, step_mode, step, mem_ready;
    logic [6:0] opcode;
    logic rd_en, ir_load, reg_write_en, busy, halted, trap;
    logic [PW-1:0] pc;
    logic [1:0] trap_cause;
    logic [CNT_W-1:0] retired_count;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;

    core_sequencer #(.MEM_SIZE(MEM_SIZE), .CNT_WIDTH(CNT_W), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .step_mode(step_mode), .step(step), .mem_ready(mem_ready), .opcode(opcode),
        .rd_en(rd_en), .ir_load(ir_load), .reg_write_en(reg_write_en), .pc(pc),
        .busy(busy), .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .retired_count(retired_count), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] rand_legal();
        return ($urandom_range(0, 1) == 0) ? OP_R : OP_I;
    endfunction

    function automatic logic [6:0] rand_illegal();
        logic [6:0] o;
        do o = 7'($urandom); while (o == OP_R || o == OP_I);
        return o;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; step_mode = 1'b0;
        step = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if (state !== 3'd0 || pc !== '0 || retired_count !== '0 || trap_cause !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_regs: state=%0d pc=%0d ret=%0d cause=%0d, want 0/0/0/0",
                     state, pc, retired_count, trap_cause);
        end
        vectors++;
        if ({rd_en, ir_load, reg_write_en, busy, halted, trap} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {rd_en, ir_load, reg_write_en, busy, halted, trap});
        end
    endtask

    task automatic test_free_run();
        do_reset();
        mem_ready = 1'b1; opcode = rand_legal(); start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            opcode = rand_legal();
            @(negedge clk);
            vectors++;
            if (state !== 3'(((c - 1) % 4) + 1) || reg_write_en !== (c % 4 == 0) ||
                rd_en !== (c % 4 == 1) || ir_load !== (c % 4 == 1)) begin
                miscompares++;
                $display("FAIL free_run c%0d: state=%0d we=%b rd=%b ir=%b want state=%0d",
                         c, state, reg_write_en, rd_en, ir_load, ((c - 1) % 4) + 1);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (pc !== 4'd3 || retired_count !== 16'd3 || state !== 3'd1) begin
            miscompares++;
            $display("FAIL free_run_end: pc=%0d ret=%0d state=%0d want 3/3/1", pc, retired_count, state);
        end
    endtask

    task automatic test_trap();
        do_reset();
        mem_ready = 1'b1; opcode = OP_R; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            opcode = (c == 6) ? rand_illegal() : rand_legal();
            @(negedge clk);
            vectors++;
            if (reg_write_en !== (c == 4)) begin
                miscompares++;
                $display("FAIL trap_we c%0d: got %b want %b", c, reg_write_en, c == 4);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd1 || pc !== 4'd1 ||
            retired_count !== 16'd1 || reg_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_entry: state=%0d trap=%b cause=%0d pc=%0d ret=%0d we=%b want 7/1/1/1/1/0",
                     state, trap, trap_cause, pc, retired_count, reg_write_en);
        end
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            vectors++;
            if (state !== 3'd7 || trap !== 1'b1 || pc !== 4'd1) begin
                miscompares++;
                $display("FAIL trap_sticky k%0d: state=%0d trap=%b pc=%0d want 7/1/1", k, state, trap, pc);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        mem_ready = 1'b1; opcode = rand_legal(); start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        halt_req = 1'b1;
        next_cycle();
        halt_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 3'd4 || reg_write_en !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_wb: state=%0d we=%b want 4/1", state, reg_write_en);
        end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            halt_req = (k == 1);
            @(negedge clk);
            vectors++;
            if (state !== 3'd6 || halted !== 1'b1 || retired_count !== 16'd1 || pc !== 4'd1) begin
                miscompares++;
                $display("FAIL halt_hold k%0d: state=%0d halted=%b ret=%0d pc=%0d want 6/1/1/1",
                         k, state, halted, retired_count, pc);
            end
            next_cycle();
        end
        halt_req = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || pc !== 4'd1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_resume: state=%0d pc=%0d halted=%b want 1/1/0", state, pc, halted);
        end
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || retired_count !== 16'd2) begin
            miscompares++;
            $display("FAIL halt_freerun: state=%0d ret=%0d want 1/2", state, retired_count);
        end
        do_reset();
        start = 1'b1; halt_req = 1'b1;
        next_cycle();
        start = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== 3'd6) begin
            miscompares++;
            $display("FAIL idle_halt_wins: state=%0d want 6", state);
        end
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1; mem_ready = 1'b1; opcode = rand_legal(); start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < 4; k++) next_cycle();
        for (int k = 0; k < 3; k++) begin
            start = (k != 0);
            @(negedge clk);
            vectors++;
            if (state !== 3'd5 || retired_count !== 16'd1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL step_pause1 k%0d: state=%0d ret=%0d busy=%b want 5/1/0",
                         k, state, retired_count, busy);
            end
            next_cycle();
        end
        start = 1'b0;
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        for (int k = 0; k < 4; k++) begin
            opcode = rand_legal();
            @(negedge clk);
            vectors++;
            if (state !== 3'(k + 1)) begin
                miscompares++;
                $display("FAIL step_seq k%0d: state=%0d want %0d", k, state, k + 1);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (state !== 3'd5 || retired_count !== 16'd2 || pc !== 4'd2) begin
            miscompares++;
            $display("FAIL step_pause2: state=%0d ret=%0d pc=%0d want 5/2/2", state, retired_count, pc);
        end
        step_mode = 1'b0;
        next_cycle();
        @(negedge clk);
        vectors++;
        if (state !== 3'd1) begin
            miscompares++;
            $display("FAIL step_release: state=%0d want 1", state);
        end
        for (int k = 0; k < 8; k++) next_cycle();
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || retired_count !== 16'd4) begin
            miscompares++;
            $display("FAIL step_freerun: state=%0d ret=%0d want 1/4", state, retired_count);
        end
    endtask

    // Reference: per instruction, FETCH waits for the first cycle with
    // mem_ready=1, then DECODE/EXECUTE/WRITEBACK take one cycle each.
    task automatic test_random();
        bit mr[NC];
        int exp_st[NC];
        bit exp_ir[NC];
        bit exp_we[NC];
        int exp_ret[NC];
        int c, n;
        for (int i = 0; i < NC; i++) mr[i] = ($urandom_range(0, 3) != 0);
        exp_st[0] = 0; exp_ir[0] = 0; exp_we[0] = 0; exp_ret[0] = 0;
        c = 1; n = 0;
        while (c < NC) begin
            while (c < NC && !mr[c]) begin
                exp_st[c] = 1; exp_ir[c] = 0; exp_we[c] = 0; exp_ret[c] = n; c++;
            end
            for (int k = 0; k < 4; k++) begin
                if (c + k < NC) begin
                    exp_st[c + k] = k + 1; exp_ir[c + k] = (k == 0);
                    exp_we[c + k] = (k == 3); exp_ret[c + k] = n;
                end
            end
            n++;
            c += 4;
        end
        do_reset();
        for (int i = 0; i < NC; i++) begin
            start = (i == 0);
            mem_ready = mr[i];
            opcode = rand_legal();
            @(negedge clk);
            vectors++;
            if (state !== 3'(exp_st[i]) || ir_load !== exp_ir[i] || reg_write_en !== exp_we[i] ||
                retired_count !== CNT_W'(exp_ret[i]) || pc !== PW'(exp_ret[i] % MEM_SIZE)) begin
                miscompares++;
                $display("FAIL random c%0d: state=%0d ir=%b we=%b ret=%0d pc=%0d want %0d/%b/%b/%0d/%0d",
                         i, state, ir_load, reg_write_en, retired_count, pc,
                         exp_st[i], exp_ir[i], exp_we[i], exp_ret[i], exp_ret[i] % MEM_SIZE);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready = 1'b1; opcode = OP_I; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k < 6; k++) next_cycle();
        #2;
        vectors++;
        if (state !== 3'd2 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL mid_pre: state=%0d pc=%0d want 2/1", state, pc);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (state !== 3'd0 || pc !== '0 || retired_count !== '0 || trap_cause !== 2'd0 ||
            {rd_en, ir_load, reg_write_en, busy, halted, trap} !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_reset: state=%0d pc=%0d ret=%0d cause=%0d flags=%b want all 0",
                     state, pc, retired_count, trap_cause,
                     {rd_en, ir_load, reg_write_en, busy, halted, trap});
        end
        do_reset();
    endtask

    task automatic test_watchdog();
        do_reset();
        mem_ready = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        for (int k = 1; k <= WDOG; k++) begin
            @(negedge clk);
            vectors++;
            if (state !== 3'd1) begin
                miscompares++;
                $display("FAIL wdog_wait c%0d: state=%0d want 1", k, state);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (state !== 3'd7 || trap_cause !== 2'd2) begin
            miscompares++;
            $display("FAIL wdog_trap: state=%0d cause=%0d want 7/2", state, trap_cause);
        end
        do_reset();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k < WDOG; k++) next_cycle();
        mem_ready = 1'b1; opcode = OP_R;
        @(negedge clk);
        vectors++;
        if (ir_load !== 1'b1) begin
            miscompares++;
            $display("FAIL wdog_late_ir: ir_load=%b want 1", ir_load);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (state !== 3'd2 || trap_cause !== 2'd0) begin
            miscompares++;
            $display("FAIL wdog_late: state=%0d cause=%0d want 2/0", state, trap_cause);
        end
`else
        for (int k = 0; k < 30; k++) next_cycle();
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || trap_cause !== 2'd0 || rd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL no_wdog: state=%0d cause=%0d rd=%b want 1/0/1", state, trap_cause, rd_en);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_trap();
        test_halt();
        test_step();
        test_random();
        test_reset_mid();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
